// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial W-bit add/subtract sequencer built around one shared 4-bit ripple-carry slice.
// Processes one nibble per clock, LSB nibble first, and chains the carry through a register.

module RCA_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < n; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end
endmodule

module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 add_n,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_sr, b_sr, acc, acc_next;
    logic [IDX_W-1:0] idx;
    logic            carry_r, op_r, sa, sb;
    logic [3:0]      slice_y, sum4;
    logic            slice_cout;
    logic            accept, last;

    assign accept  = start && (state != RUN);
    assign last    = (idx == IDX_W'(NIBBLES - 1));
    assign slice_y = b_sr[3:0] ^ {4{op_r}};

    RCA_nbit #(.n(4)) u_slice (
        .x    (a_sr[3:0]),
        .y    (slice_y),
        .cin  (carry_r),
        .sum  (sum4),
        .cout (slice_cout)
    );

    // A single-nibble build has no upper accumulator bits to shift down.
    generate
        if (NIBBLES == 1) begin : g_acc_single
            assign acc_next = sum4;
        end else begin : g_acc_multi
            assign acc_next = {sum4, acc[W-1:4]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc     <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            op_r    <= 1'b0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            op_r    <= add_n;
            carry_r <= add_n;
            idx     <= '0;
            sa      <= a[W-1];
            sb      <= b[W-1];
        end else if (state == RUN) begin
            carry_r <= slice_cout;
            a_sr    <= a_sr >> 4;
            b_sr    <= b_sr >> 4;
            acc     <= acc_next;
            idx     <= idx + IDX_W'(1);
            if (last) begin
                result <= acc_next;
                cout   <= slice_cout;
                ovf    <= (sa == (sb ^ op_r)) && (sum4[3] != sa);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl: 4-nibble instance plus a 1-nibble instance.
`timescale 1ns/1ps

module tb_nibble_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, add_n = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] result;

    logic        start1 = 1'b0, add_n1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .add_n(add_n), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    nibble_serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .add_n(add_n1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sampling is #1 after a rising edge; returns cycles waited until done.
    task automatic wait_done(input string tag, output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic op, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er,
                          input logic ec, input logic eo);
        int cyc, bc;
        @(negedge clk);
        start = 1'b1; add_n = op; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; add_n = ~op;
        wait_done(tag, cyc, bc);
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_busy_cycles"}, bc, 4);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_result_hold"}, result, er);
    endtask

    initial begin
        int cyc, bc;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst1_result", result1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_basic", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        run_op("sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_noborrow", 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
        run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

        // start during RUN is ignored, start during DONE is taken
        @(negedge clk);
        start = 1'b1; add_n = 1'b0; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h1111; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ign", cyc, bc);
        check("ign_result", result, 16'h0003);
        check("ign_cout", cout, 0);
        start = 1'b1; a = 16'h00FF; b = 16'h0001; add_n = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done("b2b", cyc, bc);
        check("b2b_gap", cyc + 1, 5);
        check("b2b_result", result, 16'h0100);

        // asynchronous reset two RUN cycles in
        @(negedge clk);
        start = 1'b1; add_n = 1'b0; a = 16'h1234; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_cout", cout, 0);
        check("arst_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("arst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_sub", 1'b1, 16'h000A, 16'h0003, 16'h0007, 1'b1, 1'b0);

        // single-nibble instance
        @(negedge clk);
        start1 = 1'b1; add_n1 = 1'b0; a1 = 4'h9; b1 = 4'h8;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_done_early", done1, 0);
        @(posedge clk); #1;
        check("n1_done", done1, 1);
        check("n1_result", result1, 4'h1);
        check("n1_cout", cout1, 1);
        check("n1_ovf", ovf1, 1);
        check("n1_busy_at_done", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
# nibble_serial_addsub_ctrl

Multi-cycle sequencer that performs W-bit add or subtract (W = 4·NIBBLES) by time-sharing a single 4-bit ripple-carry slice (`RCA_nbit #(.n(4))` plus XOR-on-y inversion). It processes one nibble per clock, least significant nibble first, and chains the carry through a register. It sits between a requester that issues operand pairs with a start/done handshake and the shared 4-bit add/sub datapath, trading latency for area on wide operands.

## Interface
- NIBBLES, default 4: operand width in nibbles, W = 4·NIBBLES, legal range ≥1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block is idle or done.
- add_n  input  1  operation select; 0 = add, 1 = subtract (a − b); captured with start.
- a  input  W  operand A; captured with start.
- b  input  W  operand B; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result, cout and ovf are updated.
- result  output  W  final sum or difference; holds until the next completion.
- cout  output  1  carry out of bit W−1; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow of the completed operation.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE→RUN on start=1.
  - RUN→RUN while nibble index < NIBBLES−1.
  - RUN→DONE when the last nibble is processed.
  - DONE→RUN on start=1.
  - DONE→IDLE otherwise.
- Start accept (IDLE or DONE with start=1):
  - Latch a into the A shift register.
  - Latch b into the B shift register.
  - Latch add_n into op_r.
  - carry_r ← add_n.
  - nibble index ← 0.
  - Latch a[W−1] and b[W−1] into sign registers for ovf.
- Each RUN cycle, slice inputs:
  - x = A_sr[3:0].
  - y = B_sr[3:0] ^ {4{op_r}}.
  - cin = carry_r.
- Each RUN edge:
  - carry_r ← slice cout.
  - A_sr and B_sr shift right by 4.
  - The slice sum nibble is shifted into the top of the accumulator, acc ← {sum4, acc[W−1:4]}.
  - Index increments.
- Completion edge (last nibble):
  - result ← {sum4, acc[W−1:4]}.
  - cout ← slice cout.
  - ovf ← (sa == sb') && (result MSB != sa), where sb' = sb ^ op_r.
  - State → DONE.
- result, cout and ovf change only on completion edges. They are never partially updated.
- start while in RUN is ignored. Operands presented then are not captured, and no queueing is performed.
- Reset values (all immediate on rst_n=0, independent of clk):
  - Outputs: busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal: state IDLE, shift registers, acc and carry_r = 0.
- Reset mid-RUN aborts the operation with no done pulse. The first start after rst_n deasserts behaves normally.

## Timing
- Let the start be captured at edge k.
- busy rises after edge k.
- RUN occupies edges k+1 … k+NIBBLES.
- done, result, cout and ovf are valid after edge k+NIBBLES, for exactly one cycle of done.
- Latency is NIBBLES cycles from capture to done.
- NIBBLES=1 gives a single RUN cycle, with done after edge k+1.
- Back-to-back: start=1 in the DONE cycle is captured at that edge. busy rises again the cycle after done, so throughput is one operation per NIBBLES+1 cycles.
- busy and done are never high together.
- The slice path is combinational within one cycle: register → XOR → 4-bit RCA → register.

## Test plan
- NIBBLES=4, add_n=0, a=0x1234, b=0x0FFF, start at edge k → done after edge k+4 with result=0x2233, cout=0, ovf=0; busy high for exactly 4 cycles.
- add_n=1, a=0x0005, b=0x0007 → result=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x0007, b=0x0005 → result=0x0002, cout=1, ovf=0.
- Overflow and carry edges:
  - 0x7FFF+0x0001 → 0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0.
  - subtract 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- Handshake checks:
  - Assert start with a=0x1111, b=0x1111 in the second RUN cycle of 0x0001+0x0002 → ignored; result=0x0003.
  - Then start=1 during the done cycle with 0x00FF+0x0001 → captured; next done gives 0x0100 five cycles after the previous done.
- Reset during RUN:
  - Drop rst_n after 2 RUN cycles → busy, done, result, cout and ovf go to 0 immediately, with no done pulse.
  - After release, 0x000A−0x0003 → 0x0007, cout=1.
- NIBBLES=1 build: 0x9+0x8 → result=0x1, cout=1, ovf=1, done one cycle after capture.
